// File: rtl/phase_sequencer_if.sv
// Host-side bundle for the phase sequencer: run request, back-pressure,
// phase lengths in; index, phase enables and handshake status out.
interface phase_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start_i;
  logic             stall_i;
  logic [CNT_W-1:0] i_num_load;
  logic [CNT_W-1:0] i_num_comp;
  logic [CNT_W-1:0] i_num_drain;
  logic [CNT_W-1:0] cnt_o;
  logic             load_en_o;
  logic             comp_en_o;
  logic             drain_en_o;
  logic [2:0]       phase_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, stall_i, i_num_load, i_num_comp, i_num_drain,
    input  cnt_o, load_en_o, comp_en_o, drain_en_o, phase_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stall_i, i_num_load, i_num_comp, i_num_drain,
    output cnt_o, load_en_o, comp_en_o, drain_en_o, phase_o, busy_o, done_o
  );
endinterface

// File: rtl/phase_sequencer.sv
// Steps one computation through LOAD, COMP and DRAIN, skipping empty phases,
// with a per-phase index and a one-cycle DONE pulse back to the host.
module phase_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  phase_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COMP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [CNT_W-1:0] len_load_r, len_comp_r, len_drain_r;
  logic [CNT_W-1:0] cur_len_s;
  logic             last_s;

  // First phase after 'from' with a nonzero length, or DONE when none is left.
  function automatic state_t next_phase(input state_t from,
                                        input logic [CNT_W-1:0] l,
                                        input logic [CNT_W-1:0] c,
                                        input logic [CNT_W-1:0] d);
    state_t nxt;
    case (from)
      ST_IDLE:  nxt = (l != CNT_ZERO) ? ST_LOAD :
                      (c != CNT_ZERO) ? ST_COMP :
                      (d != CNT_ZERO) ? ST_DRAIN : ST_DONE;
      ST_LOAD:  nxt = (c != CNT_ZERO) ? ST_COMP :
                      (d != CNT_ZERO) ? ST_DRAIN : ST_DONE;
      ST_COMP:  nxt = (d != CNT_ZERO) ? ST_DRAIN : ST_DONE;
      default:  nxt = ST_DONE;
    endcase
    return nxt;
  endfunction

  // State, index and latched lengths.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      len_load_r  <= CNT_ZERO;
      len_comp_r  <= CNT_ZERO;
      len_drain_r <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if ((state_r == ST_IDLE) && bus.start_i) begin
        len_load_r  <= bus.i_num_load;
        len_comp_r  <= bus.i_num_comp;
        len_drain_r <= bus.i_num_drain;
      end
    end
  end

  // Next state and next index.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    cur_len_s    = CNT_ZERO;
    case (state_r)
      ST_LOAD:  cur_len_s = len_load_r;
      ST_COMP:  cur_len_s = len_comp_r;
      ST_DRAIN: cur_len_s = len_drain_r;
      default:  cur_len_s = CNT_ZERO;
    endcase
    // Active phases are only ever entered with a nonzero length.
    last_s = (cnt_r == (cur_len_s - CNT_ONE));
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (bus.start_i) begin
          state_next_s = next_phase(ST_IDLE, bus.i_num_load, bus.i_num_comp, bus.i_num_drain);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD, ST_COMP, ST_DRAIN: begin
        if (bus.stall_i) begin
          state_next_s = state_r;
          cnt_next_s   = cnt_r;
        end else if (last_s) begin
          state_next_s = next_phase(state_r, len_load_r, len_comp_r, len_drain_r);
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = state_r;
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  logic             load_en_s, comp_en_s, drain_en_s, busy_s, done_s;
  logic [2:0]       phase_s;

  // Output decode; enables are gated by stall in the same cycle.
  always_comb begin
    load_en_s  = (state_r == ST_LOAD)  & ~bus.stall_i;
    comp_en_s  = (state_r == ST_COMP)  & ~bus.stall_i;
    drain_en_s = (state_r == ST_DRAIN) & ~bus.stall_i;
    busy_s     = (state_r != ST_IDLE);
    done_s     = (state_r == ST_DONE);
    phase_s    = state_r;
  end

  assign bus.cnt_o      = cnt_r;
  assign bus.load_en_o  = load_en_s;
  assign bus.comp_en_o  = comp_en_s;
  assign bus.drain_en_o = drain_en_s;
  assign bus.phase_o    = phase_s;
  assign bus.busy_o     = busy_s;
  assign bus.done_o     = done_s;
endmodule
